gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 105 ++++++++++
 tb/tb_gray_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered Gray-code view.
//   - bin_out and gray_out both come from flops loaded on the same edge, so
//     they never skew relative to each other.
//   - SATURATE=0 wraps at the limits, SATURATE=1 holds at the limits; in
//     both modes wrap pulses for one cycle after a step attempted at a limit.
//   - Optional synchronous load is compiled in when GRAY_COUNTER_LOAD_EN is
//     defined; without it the count changes only through rst and en.
module gray_counter #(
  parameter int DATA_WIDTH = 8,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
`ifdef GRAY_COUNTER_LOAD_EN
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
`endif
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ZERO_VAL = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ONE_VAL  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Binary to reflected Gray code: each bit XORed with its more significant neighbour.
  function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
    return b ^ {1'b0, b[DATA_WIDTH-1:1]};
  endfunction

  logic [DATA_WIDTH-1:0] bin_r;
  logic [DATA_WIDTH-1:0] gray_r;
  logic                  wrap_r;

  logic                  load_s;
  logic [DATA_WIDTH-1:0] load_val_s;
  logic                  at_limit_s;
  logic [DATA_WIDTH-1:0] step_val_s;
  logic [DATA_WIDTH-1:0] bin_nxt_s;
  logic                  wrap_nxt_s;

`ifdef GRAY_COUNTER_LOAD_EN
  assign load_s     = load;
  assign load_val_s = load_bin;
`else
  // Load path is tied off so the counter moves only through rst and en.
  assign load_s     = 1'b0;
  assign load_val_s = ZERO_VAL;
`endif

  // Limit detection and the modular step in the current direction.
  always_comb begin
    at_limit_s = 1'b0;
    step_val_s = bin_r;
    if (up_dn) begin
      at_limit_s = (bin_r == MAX_VAL);
      step_val_s = bin_r + ONE_VAL;
    end else begin
      at_limit_s = (bin_r == ZERO_VAL);
      step_val_s = bin_r - ONE_VAL;
    end
  end

  // Next-state selection with priority load > en > hold.
  always_comb begin
    bin_nxt_s  = bin_r;
    wrap_nxt_s = 1'b0;
    if (load_s) begin
      bin_nxt_s  = load_val_s;
      wrap_nxt_s = 1'b0;
    end else if (en) begin
      wrap_nxt_s = at_limit_s;
      if (SATURATE && at_limit_s) begin
        bin_nxt_s = bin_r;
      end else begin
        bin_nxt_s = step_val_s;
      end
    end else begin
      bin_nxt_s  = bin_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // Count, Gray and wrap registers; Gray is derived from the next binary value
  // so both views update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_r  <= ZERO_VAL;
      gray_r <= ZERO_VAL;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= bin_nxt_s;
      gray_r <= bin2gray(bin_nxt_s);
      wrap_r <= wrap_nxt_s;
    end
  end

  assign bin_out  = bin_r;
  assign gray_out = gray_r;
  assign wrap     = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: one wrapping and one saturating
// instance driven in lockstep, compared against an integer reference model.
// Load tests are included when GRAY_COUNTER_LOAD_EN is defined.
module tb_gray_counter;

  localparam int W   = 8;
  localparam int MAX = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;

  logic [W-1:0] bin0, gray0, bin1, gray1;
  logic         wrap0, wrap1;

  gray_counter #(.DATA_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
`ifdef GRAY_COUNTER_LOAD_EN
    .load(load), .load_bin(load_bin),
`endif
    .bin_out(bin0), .gray_out(gray0), .wrap(wrap0)
  );

  gray_counter #(.DATA_WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
`ifdef GRAY_COUNTER_LOAD_EN
    .load(load), .load_bin(load_bin),
`endif
    .bin_out(bin1), .gray_out(gray1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: plain integer counts and expected wrap flags.
  int m0 = 0, m1 = 0;
  bit mw0 = 1'b0, mw1 = 1'b0;

  function automatic int model_next(input int c, input bit sat, input bit e, input bit up,
                                    input bit ld, input int lv, output bit w);
    w = 1'b0;
    if (ld) return lv;
    if (!e) return c;
    if (up) begin
      if (c == MAX) begin
        w = 1'b1;
        return sat ? MAX : 0;
      end
      return c + 1;
    end else begin
      if (c == 0) begin
        w = 1'b1;
        return sat ? 0 : MAX;
      end
      return c - 1;
    end
  endfunction

  function automatic int gray_of(input int c);
    return c ^ (c / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_bin0"},  {24'h0, bin0},  m0);
    chk({tag, "_gray0"}, {24'h0, gray0}, gray_of(m0));
    chk({tag, "_wrap0"}, {31'h0, wrap0}, {31'h0, mw0});
    chk({tag, "_bin1"},  {24'h0, bin1},  m1);
    chk({tag, "_gray1"}, {24'h0, gray1}, gray_of(m1));
    chk({tag, "_wrap1"}, {31'h0, wrap1}, {31'h0, mw1});
  endtask

  // One clock: drive inputs, advance the model, sample shortly after the edge.
  task automatic step(input bit e, input bit up, input bit ld, input int lv, input string tag);
    bit w;
    en       = e;
    up_dn    = up;
`ifdef GRAY_COUNTER_LOAD_EN
    load     = ld;
    load_bin = lv[W-1:0];
`else
    load     = 1'b0;
    load_bin = '0;
`endif
    @(posedge clk);
`ifdef GRAY_COUNTER_LOAD_EN
    m0 = model_next(m0, 1'b0, e, up, ld, lv, w); mw0 = w;
    m1 = model_next(m1, 1'b1, e, up, ld, lv, w); mw1 = w;
`else
    m0 = model_next(m0, 1'b0, e, up, 1'b0, 0, w); mw0 = w;
    m1 = model_next(m1, 1'b1, e, up, 1'b0, 0, w); mw1 = w;
`endif
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    m0 = 0; m1 = 0; mw0 = 1'b0; mw1 = 1'b0;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    int bad_pairs;
    int wraps;

    // Reset state, checked before any clock edge.
    rst = 1'b1;
    #2;
    check_all("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Three up steps: 01/02/03, Gray 01/03/02.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, "up3");

    // Hold, then direction change without a dead cycle.
    step(1'b0, 1'b1, 1'b0, 0, "hold");
    step(1'b1, 1'b0, 1'b0, 0, "dir_down");
    step(1'b1, 1'b1, 1'b0, 0, "dir_up");

    // Down from zero: wrapper goes to FF, saturator holds 00 with wrap both cycles.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 0, "sat_down1");
    step(1'b1, 1'b0, 1'b0, 0, "sat_down2");

`ifdef GRAY_COUNTER_LOAD_EN
    // Load FF then count up through the wrap.
    step(1'b0, 1'b1, 1'b1, 8'hFF, "load_ff");
    step(1'b1, 1'b1, 1'b0, 0, "wrap_up");
    step(1'b1, 1'b1, 1'b0, 0, "after_wrap");
    // Load wins over en.
    step(1'b1, 1'b1, 1'b1, 8'h55, "load_55");
    // Load at a limit with en does not pulse wrap.
    step(1'b1, 1'b1, 1'b1, 8'h00, "load_00");
    step(1'b1, 1'b1, 1'b1, 8'h42, "load_42");
`else
    do_reset();
    for (int i = 0; i < 66; i++) step(1'b1, 1'b1, 1'b0, 0, "to_42");
`endif

    // Asynchronous reset between edges at count 0x42.
    chk("pre_rst_42", {24'h0, bin0}, 32'h42);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    #1;
    m0 = 0; m1 = 0; mw0 = 1'b0; mw1 = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 0, "after_rst");

    // Free run of 256 up steps from zero: single-bit Gray changes, one wrap pulse.
    do_reset();
    prev_gray = gray0;
    bad_pairs = 0;
    wraps     = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 1'b0, 0, "free");
      if ($countones(prev_gray ^ gray0) != 1) bad_pairs++;
      if (wrap0) wraps++;
      prev_gray = gray0;
    end
    chk("gray_hamming", bad_pairs, 0);
    chk("wrap_once", wraps, 1);

    // Randomized mix of enable, direction and (when present) load.
    for (int i = 0; i < 400; i++) begin
      bit r_en, r_up, r_ld;
      int r_val;
      r_en  = ($urandom_range(0, 9) < 7);
      r_up  = $urandom_range(0, 1);
      r_ld  = ($urandom_range(0, 9) == 0);
      r_val = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? MAX : 0) : $urandom_range(0, MAX);
      step(r_en, r_up, r_ld, r_val, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
